// File: rtl/ascon_pkg.sv
// Shared types for the Ascon-p sequencer.
// State layout and controller FSM encoding.
package ascon_pkg;

  localparam logic [3:0] ASCON_ROUNDS_MAX = 4'd12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/ascon_perm_ctrl.sv
// Ascon-p round sequencer: owns the 320-bit state,
// iterates an external UROL-round datapath, returns the result.
import ascon_pkg::*;

module ascon_perm_ctrl #(
  parameter int unsigned UROL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   in_rounds_i,
  input  logic [319:0] in_state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [319:0] out_state_o,
  output logic [3:0]   perm_round_cnt_o,
  output logic [319:0] perm_x_o,
  input  logic [319:0] perm_x_i,
  output logic         busy_o,
  output logic         lut_lock_o,
  output logic         err_o
);

  localparam logic [3:0] STEP = 4'(UROL);

  ctrl_state_e  st_q, st_d;
  ascon_state_t x_q, x_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         err_q, err_d;

  logic         req_legal;
  logic [3:0]   rnd_nxt;

  assign req_legal = (in_rounds_i != 4'd0)
                  && (in_rounds_i <= ASCON_ROUNDS_MAX)
                  && ((UROL == 1) || !in_rounds_i[0]);
  assign rnd_nxt   = rnd_q + STEP;

  always_comb begin
    st_d  = st_q;
    x_d   = x_q;
    rnd_d = rnd_q;
    err_d = 1'b0;
    if (flush_i) begin
      // abort: keep the state bits, drop the job
      st_d  = IDLE;
      rnd_d = 4'd0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (in_valid_i) begin
            if (req_legal) begin
              x_d   = ascon_state_t'(in_state_i);
              rnd_d = ASCON_ROUNDS_MAX - in_rounds_i;
              st_d  = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          x_d   = ascon_state_t'(perm_x_i);
          rnd_d = rnd_nxt;
          if (rnd_nxt == ASCON_ROUNDS_MAX) begin
            st_d = DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            st_d = IDLE;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= IDLE;
      x_q   <= '0;
      rnd_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      rnd_q <= rnd_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    in_ready_o       = (st_q == IDLE);
    out_valid_o      = (st_q == DONE);
    busy_o           = (st_q != IDLE);
    lut_lock_o       = (st_q != IDLE);
    err_o            = err_q;
    perm_round_cnt_o = (st_q == RUN) ? rnd_q : 4'd0;
    perm_x_o         = x_q;
    out_state_o      = x_q;
  end

endmodule
